// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_multi
// Brief   : SPI master with per-transfer CPOL/CPHA, one-hot chip selects and
//           a valid/ready word interface.
// Revision: 1.0
// ============================================================================
module spi_master_multi #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CS         = 4,
    parameter int CLOCK_DIVISION = 100,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          axiiv,
    input  logic [DATA_WIDTH-1:0]                         axiid,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] axiics,
    input  logic [1:0]                                    axiimode,
    output logic                                          axiready,
    output logic                                          axiov,
    output logic [DATA_WIDTH-1:0]                         axiod,
    output logic [NUM_CS-1:0]                             spi_cs_n,
    output logic                                          spi_clk,
    output logic                                          spi_dout,
    input  logic                                          spi_din
);

    localparam int c_H      = CLOCK_DIVISION / 2;
    localparam int c_CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int c_DIV_W  = $clog2(CLOCK_DIVISION + 1);
    localparam int c_EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int c_GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(c_H - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * DATA_WIDTH);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP_CYCLES);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEAD  = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_TRAIL = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_EDGE_W-1:0]   r_edge;
    logic [c_GAP_W-1:0]    r_gap;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_axiod;
    logic [NUM_CS-1:0]     r_cs_n;
    logic                  r_cpha;
    logic                  r_sclk;
    logic                  r_dout;
    logic                  r_axiov;
    logic                  r_din_s1;
    logic                  r_din_s2;
    logic                  r_sample_pend;

    logic                  w_accept;
    logic                  w_edge;
    logic                  w_trail_done;
    logic                  w_gap_done;
    logic                  w_drive;
    logic                  w_sample;
    logic [c_EDGE_W-1:0]   w_edge_num;
    logic [NUM_CS-1:0]     w_cs_dec;

    // Out-of-range indices match no bit, so the transfer runs with no CS low.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign w_cs_dec[gi] = (axiics != c_CS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)     w_state_next = c_LEAD;
            c_LEAD:  if (w_edge)       w_state_next = c_SHIFT;
            c_SHIFT: if (w_edge && (w_edge_num == c_EDGE_LAST)) w_state_next = c_TRAIL;
            c_TRAIL: if (w_trail_done) w_state_next = c_GAP;
            c_GAP:   if (w_gap_done)   w_state_next = c_IDLE;
            default:                   w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        axiready     = 1'b0;
        w_accept     = 1'b0;
        w_edge       = 1'b0;
        w_trail_done = 1'b0;
        w_gap_done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                axiready = 1'b1;
                w_accept = axiiv;
            end
            c_LEAD, c_SHIFT: w_edge       = (r_div == c_DIV_LAST);
            c_TRAIL:         w_trail_done = (r_div == c_DIV_LAST);
            c_GAP:           w_gap_done   = (r_gap == c_GAP_LAST);
            default: ;
        endcase
    end

    // Edge numbers are 1-based: odd = leading, even = trailing.
    assign w_edge_num = r_edge + c_EDGE_W'(1);
    assign w_drive    = w_edge & (r_cpha ? w_edge_num[0]
                                         : (~w_edge_num[0] & (w_edge_num != c_EDGE_LAST)));
    assign w_sample   = w_edge & (r_cpha ? ~w_edge_num[0] : w_edge_num[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_edge        <= '0;
            r_gap         <= '0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_axiod       <= '0;
            r_cs_n        <= '1;
            r_cpha        <= 1'b0;
            r_sclk        <= 1'b0;
            r_dout        <= 1'b0;
            r_axiov       <= 1'b0;
            r_din_s1      <= 1'b0;
            r_din_s2      <= 1'b0;
            r_sample_pend <= 1'b0;
        end else begin
            r_din_s1      <= spi_din;
            r_din_s2      <= r_din_s1;
            r_axiov       <= 1'b0;
            // Sample one cycle after the edge so MISO has crossed the synchroniser.
            r_sample_pend <= w_sample;
            if (r_sample_pend) begin
                r_rx <= {r_rx[DATA_WIDTH-2:0], r_din_s2};
            end
            if (r_state == c_GAP) begin
                r_gap <= r_gap + c_GAP_W'(1);
            end else begin
                r_gap <= '0;
            end
            if (w_accept) begin
                r_div  <= '0;
                r_edge <= '0;
                r_rx   <= '0;
                r_cpha <= axiimode[0];
                r_sclk <= axiimode[1];
                r_cs_n <= w_cs_dec;
                if (axiimode[0]) begin
                    r_tx   <= axiid;
                    r_dout <= 1'b0;
                end else begin
                    r_tx   <= {axiid[DATA_WIDTH-2:0], 1'b0};
                    r_dout <= axiid[DATA_WIDTH-1];
                end
            end else if (w_edge) begin
                r_div  <= '0;
                r_edge <= w_edge_num;
                r_sclk <= ~r_sclk;
                if (w_drive) begin
                    r_dout <= r_tx[DATA_WIDTH-1];
                    r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                end
            end else if (w_trail_done) begin
                r_div   <= '0;
                r_cs_n  <= '1;
                r_dout  <= 1'b0;
                r_axiov <= 1'b1;
                r_axiod <= r_rx;
            end else if ((r_state == c_LEAD) || (r_state == c_SHIFT) || (r_state == c_TRAIL)) begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end
    end

    assign axiov    = r_axiov;
    assign axiod    = r_axiod;
    assign spi_cs_n = r_cs_n;
    assign spi_clk  = r_sclk;
    assign spi_dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_multi
// Brief   : Self-checking bench for spi_master_multi with an SPI slave model.
// Revision: 1.0
// ============================================================================
module tb_spi_master_multi;

    localparam int c_W     = 8;
    localparam int c_CDIV  = 4;
    localparam int c_GAPC  = 4;
    localparam int c_T_OV  = 1 + (2 * c_W + 1) * (c_CDIV / 2);
    localparam int c_T_RDY = c_T_OV + 1 + c_GAPC;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       axiiv = 1'b0;
    logic [7:0] axiid = '0;
    logic [1:0] axiics = '0;
    logic [1:0] axiimode = '0;
    logic       axiready, axiov, spi_clk, spi_dout, spi_din;
    logic [7:0] axiod;
    logic [3:0] spi_cs_n;

    logic       axiiv3 = 1'b0;
    logic [7:0] axiid3 = '0;
    logic [1:0] axiics3 = '0;
    logic [1:0] axiimode3 = '0;
    logic       axiready3, axiov3, sclk3, dout3;
    logic [7:0] axiod3;
    logic [2:0] cs3;

    int         n_cmp = 0;
    int         n_err = 0;
    exp_t       sb[$];

    int         cyc = 0;
    int         cs_fall_cyc = 0, cs_rise_cyc = 0, first_edge = 0, last_edge = 0;
    int         edges = 0, bad_dout = 0, multi_low = 0, gap_len = 0, ov_cnt = 0, cs3_low = 0;
    logic [3:0] cs_val = '1;
    logic       cs_fall_sclk = 1'b0;
    logic [7:0] s_rx = '0;
    logic [7:0] sl_word = '0;
    logic       sl_din = 1'b0, sl_cpol = 1'b0, sl_cpha = 1'b0, loopback = 1'b1;
    logic       prev_cs_low = 1'b0, prev_sclk = 1'b0, prev_dout = 1'b0;

    assign spi_din = loopback ? spi_dout : sl_din;

    always #5 clk = ~clk;

    spi_master_multi #(
        .DATA_WIDTH(c_W), .NUM_CS(4), .CLOCK_DIVISION(c_CDIV), .GAP_CYCLES(c_GAPC)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .axiics(axiics),
        .axiimode(axiimode), .axiready(axiready), .axiov(axiov), .axiod(axiod),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_dout(spi_dout), .spi_din(spi_din)
    );

    spi_master_multi #(
        .DATA_WIDTH(c_W), .NUM_CS(3), .CLOCK_DIVISION(c_CDIV), .GAP_CYCLES(c_GAPC)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv3), .axiid(axiid3), .axiics(axiics3),
        .axiimode(axiimode3), .axiready(axiready3), .axiov(axiov3), .axiod(axiod3),
        .spi_cs_n(cs3), .spi_clk(sclk3), .spi_dout(dout3), .spi_din(dout3)
    );

    // Bus monitor and slave model, evaluated just after each rising edge.
    initial begin
        forever begin
            int  idx;
            logic cs_low;
            @(posedge clk);
            #1;
            cyc++;
            cs_low = (spi_cs_n != 4'hF);
            if (cs_low && !prev_cs_low) begin
                gap_len      = cyc - cs_rise_cyc;
                cs_fall_cyc  = cyc;
                cs_val       = spi_cs_n;
                cs_fall_sclk = spi_clk;
                edges        = 0;
                bad_dout     = 0;
                s_rx         = '0;
            end
            if (!cs_low && prev_cs_low) cs_rise_cyc = cyc;
            if (cs_low) begin
                if ($countones(~spi_cs_n) != 1) multi_low++;
                if (prev_cs_low && (spi_clk != prev_sclk)) begin
                    edges++;
                    if (edges == 1) first_edge = cyc;
                    last_edge = cyc;
                    if (sl_cpha ? (edges % 2 == 0) : (edges % 2 == 1)) s_rx = {s_rx[6:0], spi_dout};
                end
                if (prev_cs_low && (spi_dout != prev_dout) &&
                    !((spi_clk != prev_sclk) && (spi_clk == (sl_cpha ? !sl_cpol : sl_cpol))))
                    bad_dout++;
                idx = sl_cpha ? ((edges == 0) ? 0 : (edges - 1) / 2) : edges / 2;
                if (idx > 7) idx = 7;
                sl_din = sl_word[7 - idx];
            end
            if (axiov) ov_cnt++;
            if (cs3 != 3'b111) cs3_low++;
            prev_cs_low = cs_low;
            prev_sclk   = spi_clk;
            prev_dout   = spi_dout;
        end
    end

    task automatic start(input logic [7:0] d, input logic [1:0] cs, input logic [1:0] mode,
                         output int c0);
        int n = 0;
        @(negedge clk);
        while (!axiready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!axiready) begin
            n_cmp++; n_err++;
            $display("FAIL start_ready: axiready=%b, want 1", axiready);
        end
        sl_cpol  = mode[1];
        sl_cpha  = mode[0];
        axiid    = d;
        axiics   = cs;
        axiimode = mode;
        axiiv    = 1'b1;
        c0       = cyc;
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    task automatic wait_ov(output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (axiov) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (spi_cs_n !== 4'hF) begin
            n_err++; $display("FAIL reset_cs: got %b want 1111", spi_cs_n);
        end
        n_cmp++;
        if ({spi_clk, spi_dout, axiov, axiready} !== 4'b0001) begin
            n_err++; $display("FAIL reset_ctl: {clk,dout,ov,ready} got %b want 0001",
                              {spi_clk, spi_dout, axiov, axiready});
        end
        n_cmp++;
        if (axiod !== 8'h00) begin
            n_err++; $display("FAIL reset_axiod: got %h want 00", axiod);
        end
        n_cmp++;
        if ({cs3, axiready3} !== 4'b1111) begin
            n_err++; $display("FAIL reset_dut3: {cs,ready} got %b want 1111", {cs3, axiready3});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        int c0, t, n;
        bit ok;
        exp_t e;
        loopback = 1'b1;
        start(8'hA5, 2'd0, 2'b00, c0);
        sb.push_back('{8'hA5, c0 + c_T_OV});
        wait_ov(ok, t);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || t !== e.cyc) begin
            n_err++; $display("FAIL m0_ov_time: got cycle %0d (seen=%0b) want %0d", t - c0, ok, e.cyc - c0);
        end
        n_cmp++;
        if (axiod !== e.data) begin
            n_err++; $display("FAIL m0_axiod: got %h want %h", axiod, e.data);
        end
        n_cmp++;
        if (cs_val !== 4'b1110) begin
            n_err++; $display("FAIL m0_cs: got %b want 1110", cs_val);
        end
        n_cmp++;
        if (cs_fall_cyc - c0 !== 1 || cs_rise_cyc - c0 !== c_T_OV) begin
            n_err++; $display("FAIL m0_cs_window: got %0d..%0d want 1..%0d",
                              cs_fall_cyc - c0, cs_rise_cyc - c0, c_T_OV);
        end
        n_cmp++;
        if (edges !== 16 || first_edge - c0 !== 3 || last_edge - c0 !== 33) begin
            n_err++; $display("FAIL m0_edges: got n=%0d first=%0d last=%0d want 16/3/33",
                              edges, first_edge - c0, last_edge - c0);
        end
        n_cmp++;
        if (bad_dout !== 0 || s_rx !== 8'hA5 || cs_fall_sclk !== 1'b0) begin
            n_err++; $display("FAIL m0_mosi: got bad=%0d rx=%h sclk0=%b want 0/a5/0",
                              bad_dout, s_rx, cs_fall_sclk);
        end
        n = 0;
        while (!axiready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (cyc - c0 !== c_T_RDY) begin
            n_err++; $display("FAIL m0_ready: got cycle %0d want %0d", cyc - c0, c_T_RDY);
        end
    endtask

    task automatic test_mode3();
        int c0, t;
        bit ok;
        exp_t e;
        loopback = 1'b0;
        sl_word  = 8'h3C;
        start(8'hC3, 2'd2, 2'b11, c0);
        sb.push_back('{8'h3C, c0 + c_T_OV});
        wait_ov(ok, t);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || t !== e.cyc || axiod !== e.data) begin
            n_err++; $display("FAIL m3_rx: got %h at %0d want %h at %0d", axiod, t - c0, e.data, e.cyc - c0);
        end
        n_cmp++;
        if (cs_val !== 4'b1011) begin
            n_err++; $display("FAIL m3_cs: got %b want 1011", cs_val);
        end
        n_cmp++;
        if (cs_fall_sclk !== 1'b1 || spi_clk !== 1'b1) begin
            n_err++; $display("FAIL m3_cpol: got lead=%b idle=%b want 1/1", cs_fall_sclk, spi_clk);
        end
        n_cmp++;
        if (bad_dout !== 0 || s_rx !== 8'hC3 || edges !== 16) begin
            n_err++; $display("FAIL m3_mosi: got bad=%0d rx=%h edges=%0d want 0/c3/16", bad_dout, s_rx, edges);
        end
    endtask

    task automatic test_modes12();
        logic [7:0] tx [2] = '{8'h6B, 8'hD4};
        for (int m = 1; m <= 2; m++) begin
            int c0, t;
            bit ok;
            exp_t e;
            logic [1:0] mode;
            mode     = 2'(m);
            loopback = 1'b0;
            sl_word  = 8'h81;
            start(tx[m-1], 2'(m), mode, c0);
            sb.push_back('{8'h81, c0 + c_T_OV});
            wait_ov(ok, t);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || t !== e.cyc || axiod !== e.data) begin
                n_err++; $display("FAIL mode%0d_rx: got %h at %0d want %h at %0d",
                                  m, axiod, t - c0, e.data, e.cyc - c0);
            end
            n_cmp++;
            if (bad_dout !== 0 || s_rx !== tx[m-1]) begin
                n_err++; $display("FAIL mode%0d_mosi: got bad=%0d rx=%h want 0/%h", m, bad_dout, s_rx, tx[m-1]);
            end
            n_cmp++;
            if (cs_fall_sclk !== mode[1] || edges !== 16) begin
                n_err++; $display("FAIL mode%0d_clk: got lead=%b edges=%0d want %b/16",
                                  m, cs_fall_sclk, edges, mode[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, acc2, ovs, n;
        exp_t e;
        loopback = 1'b1;
        n = 0;
        @(negedge clk);
        while (!axiready && n < 100) begin
            @(negedge clk);
            n++;
        end
        sl_cpol  = 1'b0;
        sl_cpha  = 1'b0;
        axiid    = 8'h11;
        axiics   = 2'd1;
        axiimode = 2'b00;
        axiiv    = 1'b1;
        c0       = cyc;
        sb.push_back('{8'h11, c0 + c_T_OV});
        sb.push_back('{8'h22, c0 + c_T_RDY + c_T_OV});
        acc2 = -1;
        ovs  = 0;
        @(negedge clk);
        for (int i = 0; i < 150 && ovs < 2; i++) begin
            if (axiov) begin
                ovs++;
                e = sb.pop_front();
                n_cmp++;
                if (cyc !== e.cyc || axiod !== e.data) begin
                    n_err++; $display("FAIL b2b_rx%0d: got %h at %0d want %h at %0d",
                                      ovs, axiod, cyc - c0, e.data, e.cyc - c0);
                end
            end
            if (acc2 >= 0) begin
                axiiv = 1'b0;
            end else begin
                axiid = (cyc - c0 < 20) ? 8'hEE : 8'h22;
                if (axiready && axiiv) acc2 = cyc;
            end
            @(negedge clk);
        end
        axiiv = 1'b0;
        n_cmp++;
        if (ovs !== 2) begin
            n_err++; $display("FAIL b2b_count: got %0d axiov pulses want 2", ovs);
        end
        n_cmp++;
        if (acc2 - c0 !== c_T_RDY) begin
            n_err++; $display("FAIL b2b_accept: got cycle %0d want %0d", acc2 - c0, c_T_RDY);
        end
        n_cmp++;
        if (gap_len !== c_GAPC + 2) begin
            n_err++; $display("FAIL b2b_gap: got %0d cs-high cycles want %0d", gap_len, c_GAPC + 2);
        end
        sb.delete();
    endtask

    task automatic test_cs_out_of_range();
        int c0, t, n, base;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!axiready3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        base      = cs3_low;
        axiid3    = 8'h3D;
        axiics3   = 2'd3;
        axiimode3 = 2'b00;
        axiiv3    = 1'b1;
        c0        = cyc;
        sb.push_back('{8'h3D, c0 + c_T_OV});
        @(negedge clk);
        axiiv3 = 1'b0;
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            @(negedge clk);
            if (axiov3) t = cyc;
        end
        e = sb.pop_front();
        n_cmp++;
        if (t !== e.cyc) begin
            n_err++; $display("FAIL oor_ov_time: got %0d want %0d", t - c0, e.cyc - c0);
        end
        n_cmp++;
        if (axiod3 !== e.data) begin
            n_err++; $display("FAIL oor_axiod: got %h want %h", axiod3, e.data);
        end
        n_cmp++;
        if (cs3_low !== base) begin
            n_err++; $display("FAIL oor_cs: got %0d cycles with cs low want 0", cs3_low - base);
        end
    endtask

    task automatic test_reset_mid();
        int c0, t, base;
        bit ok;
        exp_t e;
        loopback = 1'b1;
        base     = ov_cnt;
        start(8'h99, 2'd0, 2'b00, c0);
        while (cyc - c0 < 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({spi_cs_n, spi_clk, axiready} !== 6'b111101) begin
            n_err++; $display("FAIL rstmid_outputs: {cs,clk,ready} got %b want 111101",
                              {spi_cs_n, spi_clk, axiready});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (ov_cnt !== base) begin
            n_err++; $display("FAIL rstmid_no_ov: got %0d axiov pulses want 0", ov_cnt - base);
        end
        start(8'h5A, 2'd3, 2'b00, c0);
        sb.push_back('{8'h5A, c0 + c_T_OV});
        wait_ov(ok, t);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || t !== e.cyc || axiod !== e.data) begin
            n_err++; $display("FAIL rstmid_next: got %h at %0d want %h at %0d", axiod, t - c0, e.data, e.cyc - c0);
        end
        n_cmp++;
        if (cs_val !== 4'b0111) begin
            n_err++; $display("FAIL rstmid_cs: got %b want 0111", cs_val);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3();
        test_modes12();
        test_back_to_back();
        test_cs_out_of_range();
        test_reset_mid();
        n_cmp++;
        if (multi_low !== 0) begin
            n_err++; $display("FAIL one_hot_cs: got %0d cycles with >1 cs low want 0", multi_low);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
